// File: rtl/preg_free_list_pkg.sv
// Shared sizing constants and FSM encoding
// for the rename-stage physical-register free list.
package preg_free_list_pkg;

  localparam int C_PHYS_REGS = 32;
  localparam int C_PR_ADDR_W = 5;
  localparam int C_ALLOC_W   = 4;
  localparam int C_CMT_W     = 3;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } fl_state_e;

endpackage

// File: rtl/preg_free_list_prio_pick.sv
// Lowest-set-bit picker: returns index of the
// lowest set bit of i_map and a found flag.
module preg_free_list_prio_pick #(
  parameter int W  = 30,
  parameter int AW = 5
) (
  input  logic [W-1:0]  i_map,
  output logic [AW-1:0] o_idx,
  output logic          o_found
);

  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    for (int k = W - 1; k >= 0; k--) begin
      if (i_map[k]) begin
        o_idx   = AW'(k);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/preg_free_list.sv
// Speculative/architectural physical-register
// free list with in-order multi-slot allocation.
module preg_free_list
  import preg_free_list_pkg::*;
#(
  parameter int PHYS_REGS = C_PHYS_REGS,
  parameter int PR_ADDR_W = C_PR_ADDR_W,
  parameter int ALLOC_W   = C_ALLOC_W,
  parameter int CMT_W     = C_CMT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ALLOC_W-1:0]           alloc_valid,
  output logic [ALLOC_W-1:0]           alloc_grant,
  output logic [ALLOC_W*PR_ADDR_W-1:0] alloc_preg,
  output logic                         alloc_stall,
  input  logic [CMT_W-1:0]             cmt_valid,
  input  logic [CMT_W*PR_ADDR_W-1:0]   cmt_new_preg,
  input  logic [CMT_W*PR_ADDR_W-1:0]   cmt_old_preg,
  input  logic                         flush,
  output logic [PHYS_REGS-3:0]         free_pool,
  output logic [PR_ADDR_W:0]           free_cnt,
  output logic                         dbl_free_err
);

  localparam int W  = PHYS_REGS - 2;
  localparam int AW = PR_ADDR_W;
  localparam int CW = PR_ADDR_W + 1;

  function automatic logic [CW-1:0] popcnt(
    input logic [W-1:0] v
  );
    logic [CW-1:0] c;
    c = '0;
    for (int k = 0; k < W; k++) begin
      c = c + CW'(v[k]);
    end
    return c;
  endfunction

  fl_state_e     r_state;
  fl_state_e     w_state_nxt;
  logic [W-1:0]  r_spec_free;
  logic [W-1:0]  r_arch_free;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic          w_en;
  logic [W-1:0]  w_gmask;
  logic [W-1:0]  w_rel;
  logic [W-1:0]  w_arch_nxt;
  logic          w_dbl;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_RUN:     w_state_nxt = flush ? ST_RECOVER : ST_RUN;
      ST_RECOVER: w_state_nxt = flush ? ST_RECOVER : ST_RUN;
      default:    w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    w_en = rst & ~flush & (r_state == ST_RUN);
  end

  // Each slot picks from what earlier slots left;
  // a failed valid slot blocks all later slots.
  for (genvar g = 0; g < ALLOC_W; g++) begin : g_slot
    logic [W-1:0]  w_in;
    logic [W-1:0]  w_out;
    logic          w_blk_in;
    logic          w_blk_out;
    logic [AW-1:0] w_idx;
    logic          w_found;
    logic          w_gnt;

    if (g == 0) begin : g_first
      assign w_in     = r_spec_free;
      assign w_blk_in = ~w_en;
    end else begin : g_next
      assign w_in     = g_slot[g-1].w_out;
      assign w_blk_in = g_slot[g-1].w_blk_out;
    end

    preg_free_list_prio_pick #(
      .W  (W),
      .AW (AW)
    ) u_prio_pick (
      .i_map   (w_in),
      .o_idx   (w_idx),
      .o_found (w_found)
    );

    assign w_gnt     = alloc_valid[g] & w_found & ~w_blk_in;
    assign w_blk_out = w_blk_in | (alloc_valid[g] & ~w_gnt);
    assign w_out     = w_gnt ? (w_in & ~(W'(1) << w_idx))
                             : w_in;
    assign alloc_grant[g] = w_gnt;
    assign alloc_preg[g*AW +: AW] =
      w_gnt ? (w_idx + AW'(2)) : '0;
  end

  assign w_gmask = r_spec_free & ~g_slot[ALLOC_W-1].w_out;

  assign alloc_stall = |(alloc_valid & ~alloc_grant);

  // Registers 0/1 are hard-wired, so both ports skip them.
  always_comb begin
    w_arch_nxt = r_arch_free;
    w_rel      = '0;
    w_dbl      = 1'b0;
    for (int j = 0; j < CMT_W; j++) begin
      if (cmt_valid[j]) begin
        if (cmt_old_preg[j*AW +: AW] > AW'(1)) begin
          w_dbl = w_dbl
                | r_spec_free[cmt_old_preg[j*AW +: AW] - AW'(2)]
                | w_rel[cmt_old_preg[j*AW +: AW] - AW'(2)];
          w_rel[cmt_old_preg[j*AW +: AW] - AW'(2)]      = 1'b1;
          w_arch_nxt[cmt_old_preg[j*AW +: AW] - AW'(2)] = 1'b1;
        end
        if (cmt_new_preg[j*AW +: AW] > AW'(1)) begin
          w_arch_nxt[cmt_new_preg[j*AW +: AW] - AW'(2)] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_spec_free <= '1;
      r_arch_free <= '1;
      r_cnt       <= CW'(W);
      r_err       <= 1'b0;
    end else begin
      r_arch_free <= w_arch_nxt;
      r_err       <= r_err | w_dbl;
      if (flush) begin
        r_spec_free <= w_arch_nxt;
        r_cnt       <= popcnt(w_arch_nxt);
      end else begin
        r_spec_free <= (r_spec_free & ~w_gmask) | w_rel;
        r_cnt       <= r_cnt
                     - popcnt(W'(alloc_grant))
                     + popcnt(w_rel);
      end
    end
  end

  assign free_pool    = r_spec_free;
  assign free_cnt     = r_cnt;
  assign dbl_free_err = r_err;

endmodule

// File: tb/tb_preg_free_list.sv
// Directed self-checking bench for the
// physical-register free list.
module tb_preg_free_list;

  logic        clk;
  logic        rst;
  logic [3:0]  alloc_valid;
  logic [3:0]  alloc_grant;
  logic [19:0] alloc_preg;
  logic        alloc_stall;
  logic [2:0]  cmt_valid;
  logic [14:0] cmt_new_preg;
  logic [14:0] cmt_old_preg;
  logic        flush;
  logic [29:0] free_pool;
  logic [5:0]  free_cnt;
  logic        dbl_free_err;

  int n_test = 0;
  int n_fail = 0;

  preg_free_list dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_grant  (alloc_grant),
    .alloc_preg   (alloc_preg),
    .alloc_stall  (alloc_stall),
    .cmt_valid    (cmt_valid),
    .cmt_new_preg (cmt_new_preg),
    .cmt_old_preg (cmt_old_preg),
    .flush        (flush),
    .free_pool    (free_pool),
    .free_cnt     (free_cnt),
    .dbl_free_err (dbl_free_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    n_test++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b0;
    alloc_valid  = '0;
    cmt_valid    = '0;
    cmt_new_preg = '0;
    cmt_old_preg = '0;
    flush        = 1'b0;
    tick();
    tick();

    // reset state, no grants while in reset
    alloc_valid = 4'b1111;
    #1;
    check("rst_grant", 64'(alloc_grant), 64'h0);
    check("rst_preg", 64'(alloc_preg), 64'h0);
    check("rst_cnt", 64'(free_cnt), 64'd30);
    check("rst_pool", 64'(free_pool), 64'h3FFF_FFFF);
    check("rst_err", 64'(dbl_free_err), 64'h0);

    // four-way allocation from reset
    rst = 1'b1;
    #1;
    check("a4_grant", 64'(alloc_grant), 64'hF);
    check("a4_preg", 64'(alloc_preg), 64'h29062);
    check("a4_stall", 64'(alloc_stall), 64'h0);
    tick();
    alloc_valid = 4'b0000;
    #1;
    check("a4_cnt", 64'(free_cnt), 64'd26);
    check("a4_pool", 64'(free_pool[3:0]), 64'h0);

    // commit new=2 old=0 plus flush in the same cycle
    alloc_valid  = 4'b1111;
    cmt_valid    = 3'b001;
    cmt_new_preg = 15'd2;
    cmt_old_preg = 15'd0;
    flush        = 1'b1;
    #1;
    check("fl_n_grant", 64'(alloc_grant), 64'h0);
    check("fl_n_stall", 64'(alloc_stall), 64'h1);
    tick();
    flush     = 1'b0;
    cmt_valid = 3'b000;
    #1;
    check("fl_n1_pool", 64'(free_pool), 64'h3FFF_FFFE);
    check("fl_n1_cnt", 64'(free_cnt), 64'd29);
    check("fl_n1_grant", 64'(alloc_grant), 64'h0);
    tick();
    check("fl_n2_grant", 64'(alloc_grant), 64'hF);
    check("fl_n2_preg", 64'(alloc_preg), 64'h31483);

    // reset asserted during RECOVER
    tick();
    alloc_valid = 4'b0000;
    flush       = 1'b1;
    tick();
    flush       = 1'b0;
    rst         = 1'b0;
    alloc_valid = 4'b1111;
    #1;
    check("rr_grant", 64'(alloc_grant), 64'h0);
    tick();
    rst = 1'b1;
    #1;
    check("rr_cnt", 64'(free_cnt), 64'd30);
    check("rr_pool", 64'(free_pool), 64'h3FFF_FFFF);
    check("rr_run", 64'(alloc_preg), 64'h29062);

    // invalid slots are skipped without blocking
    alloc_valid = 4'b0101;
    #1;
    check("skip_grant", 64'(alloc_grant), 64'h5);
    check("skip_preg", 64'(alloc_preg), 64'h00C02);

    // drain down to a single free register (31)
    alloc_valid = 4'b1111;
    for (int c = 0; c < 7; c++) tick();
    alloc_valid = 4'b0001;
    #1;
    check("dr_preg30", 64'(alloc_preg), 64'd30);
    tick();
    alloc_valid = 4'b0000;
    #1;
    check("dr_cnt1", 64'(free_cnt), 64'd1);
    check("dr_pool1", 64'(free_pool), 64'h2000_0000);

    // one free, slots 1 and 3 valid
    alloc_valid = 4'b1010;
    #1;
    check("k1_grant", 64'(alloc_grant), 64'h2);
    check("k1_preg", 64'(alloc_preg), 64'h003E0);
    check("k1_stall", 64'(alloc_stall), 64'h1);
    tick();

    // empty pool, release 7 while slot0 requests
    alloc_valid  = 4'b0001;
    cmt_valid    = 3'b001;
    cmt_old_preg = 15'd7;
    cmt_new_preg = 15'd31;
    #1;
    check("e_cnt", 64'(free_cnt), 64'd0);
    check("e_pool", 64'(free_pool), 64'h0);
    check("byp_grant", 64'(alloc_grant), 64'h0);
    check("byp_stall", 64'(alloc_stall), 64'h1);
    tick();
    cmt_valid = 3'b000;
    #1;
    check("rel_grant", 64'(alloc_grant), 64'h1);
    check("rel_preg", 64'(alloc_preg), 64'd7);
    check("rel_cnt", 64'(free_cnt), 64'd1);
    tick();
    alloc_valid = 4'b0000;
    #1;
    check("rel_cnt0", 64'(free_cnt), 64'd0);
    check("rel_err", 64'(dbl_free_err), 64'h0);

    // releasing hard-wired reg 1 is ignored
    rst = 1'b0;
    tick();
    rst          = 1'b1;
    cmt_valid    = 3'b001;
    cmt_old_preg = 15'd1;
    cmt_new_preg = 15'd0;
    tick();
    check("r1_err", 64'(dbl_free_err), 64'h0);
    check("r1_cnt", 64'(free_cnt), 64'd30);

    // double free of reg 10 on commit slot 2
    cmt_valid    = 3'b100;
    cmt_old_preg = 15'(10 << 10);
    tick();
    cmt_valid = 3'b000;
    #1;
    check("df_err", 64'(dbl_free_err), 64'h1);
    tick();
    tick();
    check("df_sticky", 64'(dbl_free_err), 64'h1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("df_clr", 64'(dbl_free_err), 64'h0);

    $display("[TB] %0d tests run, %0d failed",
             n_test, n_fail);
    $finish;
  end

endmodule

// File: doc/preg_free_list.md
# preg_free_list

Physical-register free-list controller for the rename stage. Each cycle it hands out up to ALLOC_W free physical registers to the rename slots, in slot order. It reclaims registers released by commit and tracks a committed ("architectural") free map, so a flush restores the speculative pool in one cycle. It sits between the decoder cells, which consume `free_pool` and produce grants, and the ROB commit port.

## Interface
- `PHYS_REGS`, default `` `PHYS_REGS `` (32): total physical registers. Registers 0 and 1 are hard-wired and never allocated or freed.
- `PR_ADDR_W`, default `` `PR_ADDR_W `` (5): physical register index width.
- `ALLOC_W`, default 4: rename slots per cycle.
- `CMT_W`, default 3: commit slots per cycle.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-low reset (reset when `rst`==0 at posedge).
- `alloc_valid`  in  ALLOC_W  slot i needs a destination register.
- `alloc_grant`  out  ALLOC_W  slot i receives `alloc_preg[i]` this cycle.
- `alloc_preg`  out  ALLOC_W*PR_ADDR_W  granted register per slot; 0 when not granted.
- `alloc_stall`  out  1  some valid slot was not granted.
- `cmt_valid`  in  CMT_W  commit slot j retires an instruction with a destination.
- `cmt_new_preg`  in  CMT_W*PR_ADDR_W  register becoming architectural.
- `cmt_old_preg`  in  CMT_W*PR_ADDR_W  previous alias being released; values 0 and 1 are ignored.
- `flush`  in  1  squash all speculative allocations.
- `free_pool`  out  PHYS_REGS-2  current speculative free bitmap; bit k corresponds to register k+2.
- `free_cnt`  out  PR_ADDR_W+1  popcount of `free_pool`.
- `dbl_free_err`  out  1  sticky error flag.

## Operation
- State:
  - `spec_free` bitmap.
  - `arch_free` bitmap.
  - `free_cnt` register.
  - 2-state FSM: RUN and RECOVER.
  - `dbl_free_err` sticky flag.
- Allocation is combinational from the current `spec_free`. Slots are scanned from 0 upward.
  - A slot with `alloc_valid`=0 is skipped and does not block later slots.
  - A valid slot is granted the lowest-index free register not already given to a lower slot.
  - The first valid slot that cannot be granted blocks every higher slot, so grants stay in order.
- Allocation is disabled (all grants 0, `alloc_stall`=|`alloc_valid`) when `flush`=1 or the FSM is in RECOVER.
- Commit, for each valid slot j:
  - Set `arch_free` and `spec_free` for `cmt_old_preg[j]`.
  - Clear `arch_free` for `cmt_new_preg[j]`.
  - Setting a bit that is already set in `spec_free` sets `dbl_free_err`.
- Flush:
  - On the next edge `spec_free` is loaded with `arch_free`, including that cycle's commit updates.
  - `free_cnt` is loaded with its popcount.
  - The FSM goes RUN→RECOVER.
  - RECOVER lasts exactly one cycle, then returns to RUN. A `flush` during RECOVER re-enters RECOVER.
- `free_cnt` next value = current − grants + commit releases, or the flush popcount. Saturation is not needed; an overflow is a double free and is flagged.
- Reset:
  - `spec_free` and `arch_free` all ones.
  - `free_cnt`=PHYS_REGS-2.
  - FSM in RUN.
  - `dbl_free_err`=0.
  - During reset, `alloc_grant`=0 and `alloc_preg`=0.

## Timing
- Grant to visible pool update takes 1 cycle. A register granted in cycle N is absent from `free_pool` in cycle N+1.
- A register released in cycle N is allocatable from cycle N+1. There is no same-cycle bypass.
- Flush in cycle N:
  - No grants in N or N+1.
  - Restored pool is visible in N+1.
  - Grants resume in N+2.
- Grant and commit release in the same cycle both apply. When they hit the same bit, the release wins, because a legal grant cannot target a non-free bit.
- Pool empty: all valid slots stall, and `free_cnt`=0.
- Pool with k free registers and more than k valid slots: the first k valid slots are granted.
- Reset asserted mid-flush or during RECOVER returns to the reset state at once.

## Structure
- `` `PHYS_REGS ``, `` `PR_ADDR_W `` and the new `` `ALLOC_W `` / `` `CMT_W `` constants belong in `constants.vh`.
- One sub-module, `prio_pick`: takes a bitmap and returns the lowest set index plus a found flag. The allocator instantiates it ALLOC_W times in a chain, masking each winner before the next stage.
- Popcount is a function local to the block.

## Test plan
- Reset, then `alloc_valid`=4'b1111 → grants 1111, pregs 2,3,4,5. Next cycle `free_cnt`=26 and `free_pool[3:0]`=0.
- `alloc_valid`=4'b1010 with only 1 free register (index 31) → slot1 gets 31 and slot3 is not granted. `alloc_stall`=1.
- Allocate 2..5, then commit `cmt_new_preg`=2 and `cmt_old_preg`=0, followed by `flush`:
  - N+1: `spec_free` equals all free except 2, and `free_cnt`=29.
  - No grants in N and N+1.
- Commit releases 7 while slot0 requests in the same cycle, with the pool otherwise empty → slot0 is not granted in N and receives 7 in N+1.
- Release an already-free register (e.g. 10 right after reset) → `dbl_free_err`=1 from the next cycle, staying set until reset.
- `rst`=0 in the RECOVER cycle → all state returns to reset values. `free_cnt`=30 on the following cycle.
